mux2x1_8_rr: RTL and testbench
==============================

# mux2x1_8_rr

Two-input, 8-bit round-robin merging mux with per-input FIFO buffering. It is the merge-side counterpart of the 1x2 8-bit demux: it collects two independently pushed byte streams into one registered output stream. The output is tagged with the source index, so a downstream demux can route each word back by `select`. It sits between the lane-side push interfaces and the single shared egress path of the adaptive PCIe switch datapath.

## Interface
Parameters:
- `DATA_W`, default 8: word width.
- `DEPTH`, default 4: words per input FIFO; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in0`  in  DATA_W  word for input 0.
- `in1`  in  DATA_W  word for input 1.
- `valid_in`  in  2  bit i qualifies `in<i>` for a push this cycle.
- `stall`  in  1  downstream not ready; freezes output and arbitration.
- `out`  out  DATA_W  registered merged word.
- `valid_out`  out  1  `out` holds a new word this cycle.
- `select_out`  out  1  source index of `out` (0 or 1).
- `full`  out  2  bit i high when FIFO i holds `DEPTH` words.
- `overflow`  out  2  one-cycle pulse: push on input i was dropped because FIFO i was full.

## Operation
- Each input has its own FIFO: `DEPTH` entries, read and write pointers modulo `DEPTH`, and a count of 0..`DEPTH` (log2(`DEPTH`)+1 bits).
- Push: `valid_in[i] && !full[i]` writes `in<i>` at the write pointer and advances it.
- `valid_in[i] && full[i]` drops the word and pulses `overflow[i]` for one cycle. Full blocks a write even if the same FIFO is popped that cycle.
- Arbitration happens each cycle with `stall == 0`. `prio` is a 1-bit register, 0 after reset.
  - Both FIFOs non-empty: grant `prio`.
  - One FIFO non-empty: grant it.
  - Neither non-empty: no grant.
  - After any grant, `prio <= ~granted`.
- On a grant, at the edge: `out <= head of granted FIFO`, `select_out <= granted`, `valid_out <= 1`, and the granted FIFO is popped.
- No grant and no stall: `valid_out <= 0`; `out` and `select_out` hold.
- `stall == 1`: no pops, `prio` holds, and `out`, `valid_out`, `select_out` all hold. Pushes continue.
- Emptiness is judged from registered counts. A word written into an empty FIFO is not visible to the arbiter until the next cycle (no bypass).
- Push and pop on the same non-full FIFO in one cycle: both occur, count unchanged.
- Reset, including mid-operation: all FIFO contents are abandoned. Pointers, counts, `prio`, `out`, `valid_out`, `select_out`, `full` and `overflow` go to 0 asynchronously. No stale word appears after reset deasserts.

## Timing
- Reset values: `out = 0`, `valid_out = 0`, `select_out = 0`, `full = 2'b00`, `overflow = 2'b00`.
- Latency: a word pushed at edge k onto an empty, unstalled path appears on `out` with `valid_out = 1` after edge k+1.
- Throughput: one word per cycle total while not stalled. With both inputs continuously backlogged the output strictly alternates sources.
- `full[i]` rises in the cycle after the push that fills FIFO i and falls in the cycle after the first pop from it.
- `overflow[i]` is asserted in the cycle after the edge at which the dropped push was sampled.
- Order is preserved per input, including across pointer wrap-around.

## Test plan
- **Reset:** hold `reset = 1` for 3 cycles with random inputs → all outputs 0. Assert `reset` between edges → outputs clear without waiting for an edge.
- **Single stream:** push 0xFF, 0xDD, 0xEE on input 0 in consecutive cycles → `out` = FF, DD, EE in consecutive cycles with `select_out = 0`. The first valid word appears one cycle after its push edge; `valid_out` drops afterwards.
- **Fair merge:** push 0xAA, 0xBB on input 0 and 0xCC, 0x99 on input 1 in the same two cycles → output order AA/0, CC/1, BB/0, 99/1, with no idle cycles.
- **Full and overflow:** with `stall = 1`, push 0x88, 0x77, 0x66, 0x55, 0x44 on input 1.
  - `full[1]` rises after the 4th push.
  - 0x44 is dropped with a one-cycle `overflow[1]` pulse.
  - Release `stall` → 88, 77, 66, 55 emitted in order, and `full[1]` clears after the first pop.
- **Reset mid-operation:** queue 3 words on each input, then assert `reset` for 1 cycle → outputs zero immediately. After release with no pushes, `valid_out` stays 0 for 10 cycles.
- **Wrap-around under stall:** push 10 sequential words (0x01..0x0A) into input 0 while toggling `stall` every 2 cycles, keeping the FIFO from overflowing → all 10 words emerge in order with no duplicates.

Source files
------------

// File: rtl/mux2x1_8_rr.sv
// -----------------------------------------------------------------------------
// mux2x1_8_rr
//
// Two-input round-robin merging mux with a small FIFO behind each input.
// Two independent push streams (in0, in1) are buffered and then merged onto
// one registered output stream. Each output word is tagged with its source
// index so a downstream 1x2 demux can route it back by select.
//
// Ports
//   clk         single clock, rising-edge active
//   reset       asynchronous, active-high; clears pointers, counts, prio and
//               all outputs immediately
//   in0, in1    DATA_W-bit words for input 0 / input 1
//   valid_in    [1:0] bit i qualifies in<i> for a push this cycle
//   stall       downstream not ready; freezes output and arbitration
//   out         registered merged word
//   valid_out   out holds a new word this cycle
//   select_out  source index of out
//   full        [1:0] bit i high while FIFO i holds DEPTH words
//   overflow    [1:0] one-cycle pulse: push on input i was dropped (FIFO full)
//
// Handshake semantics
//   Input side has no backpressure: a word is taken whenever valid_in[i] is
//   high and full[i] is low; otherwise it is dropped and overflow[i] pulses
//   on the following cycle. Output side: a word is transferred at an edge
//   where stall is low and a grant is made; at that edge out/select_out load
//   the word and valid_out goes high. While stall is high, out, select_out
//   and valid_out hold and nothing is popped, so the downstream sees a
//   frozen output. A low valid_out with stall low means no word this cycle.
//
// Parameters
//   DATA_W  word width (default 8)
//   DEPTH   words per input FIFO (default 4); must be a power of two >= 2 so
//           the pointers wrap naturally at their bit width
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mux2x1_8_rr_fifo
//
// Single-clock FIFO with registered occupancy count. Full and empty are
// decoded from the registered count only, so a word written into an empty
// FIFO becomes visible as non-empty one cycle after its write edge.
//
// Ports
//   clk, reset  clock and asynchronous active-high reset
//   push_i      write data_i at the write pointer (caller guarantees !full_o)
//   data_i      word to write
//   pop_i       advance the read pointer (caller guarantees !empty_o)
//   head_o      word at the read pointer
//   empty_o     count == 0
//   full_o      count == DEPTH
// -----------------------------------------------------------------------------
module mux2x1_8_rr_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // Storage carries no reset: after a reset the pointers and count are zero,
  // so any old contents are unreachable until overwritten.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// -----------------------------------------------------------------------------
// Top level: two FIFOs, a 1-bit round-robin arbiter and the output register.
// -----------------------------------------------------------------------------
module mux2x1_8_rr #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [1:0]        valid_in,
  input  logic              stall,
  output logic [DATA_W-1:0] out,
  output logic              valid_out,
  output logic              select_out,
  output logic [1:0]        full,
  output logic [1:0]        overflow
);

  // ---------------------------------------------------------------------------
  // Input FIFOs
  // ---------------------------------------------------------------------------
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        empty;
  logic [1:0]        full_w;
  logic [DATA_W-1:0] head0;
  logic [DATA_W-1:0] head1;

  // Full blocks a write even when the same FIFO is popped this cycle; full is
  // a registered-count decode so this never depends on the pop decision.
  assign push = valid_in & ~full_w;

  mux2x1_8_rr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push[0]),
    .data_i  (in0),
    .pop_i   (pop[0]),
    .head_o  (head0),
    .empty_o (empty[0]),
    .full_o  (full_w[0])
  );

  mux2x1_8_rr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push[1]),
    .data_i  (in1),
    .pop_i   (pop[1]),
    .head_o  (head1),
    .empty_o (empty[1]),
    .full_o  (full_w[1])
  );

  // ---------------------------------------------------------------------------
  // Arbiter
  // prio_q names the input that wins when both are non-empty. After every
  // grant it points at the other input, which gives strict alternation when
  // both FIFOs stay backlogged.
  // ---------------------------------------------------------------------------
  logic prio_q, prio_d;
  logic grant_vld;
  logic grant_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (!stall) begin
      if (!empty[0] && !empty[1]) begin
        grant_vld = 1'b1;
        grant_idx = prio_q;
      end else if (!empty[0]) begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end else if (!empty[1]) begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign pop[0] = grant_vld && (grant_idx == 1'b0);
  assign pop[1] = grant_vld && (grant_idx == 1'b1);

  // ---------------------------------------------------------------------------
  // Output register next state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;
  logic [1:0]        overflow_q, overflow_d;

  always_comb begin
    prio_d     = prio_q;
    out_d      = out_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    overflow_d = valid_in & full_w;

    // Under stall everything on the output side holds, including valid.
    if (!stall) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        out_d  = grant_idx ? head1 : head0;
        sel_d  = grant_idx;
        prio_d = ~grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      overflow_q <= 2'b00;
    end else begin
      prio_q     <= prio_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      overflow_q <= overflow_d;
    end
  end

  assign out        = out_q;
  assign valid_out  = valid_q;
  assign select_out = sel_q;
  assign full       = full_w;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mux2x1_8_rr.sv
module tb_mux2x1_8_rr;

  localparam int DATA_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [1:0]        valid_in;
  logic              stall;
  logic [DATA_W-1:0] out;
  logic              valid_out;
  logic              select_out;
  logic [1:0]        full;
  logic [1:0]        overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux2x1_8_rr #(
    .DATA_W (DATA_W),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .valid_in   (valid_in),
    .stall      (stall),
    .out        (out),
    .valid_out  (valid_out),
    .select_out (select_out),
    .full       (full),
    .overflow   (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: {select, data} in the order words must leave the mux
  // ---------------------------------------------------------------------------
  logic [DATA_W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A new word is one loaded at an edge where stall was low.
  always @(posedge clk) begin
    #1;
    if (!reset && !stall && valid_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", valid_out, 1'b0);
      end else begin
        check("out_word", {select_out, out}, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"},  out,        '0);
    check({tag, "_vo"},   valid_out,  1'b0);
    check({tag, "_sel"},  select_out, 1'b0);
    check({tag, "_full"}, full,       2'b00);
    check({tag, "_ovf"},  overflow,   2'b00);
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check(tag, exp_q.size(), 0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [1:0]        fm_sel [4];
  logic [DATA_W-1:0] d0, d1;
  int                pushed;

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    valid_in = 2'b00;
    in0      = '0;
    in1      = '0;
    fm_sel   = '{2'd0, 2'd1, 2'd0, 2'd1};

    // Reset held for 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      step();
      valid_in = 2'($urandom_range(0, 3));
      in0      = 8'($urandom_range(0, 255));
      in1      = 8'($urandom_range(0, 255));
      stall    = 1'($urandom_range(0, 1));
      check_zero("rst_hold");
    end
    step();
    valid_in = 2'b00;
    stall    = 1'b0;
    reset    = 1'b0;
    step();

    // Single stream on input 0
    step(); in0 = 8'hFF; valid_in = 2'b01; exp_q.push_back({1'b0, 8'hFF});
    step(); check("ss_no_bypass", valid_out, 1'b0);
            in0 = 8'hDD; exp_q.push_back({1'b0, 8'hDD});
    step(); check("ss_first_vo", valid_out, 1'b1); check("ss_first_out", out, 8'hFF);
            in0 = 8'hEE; exp_q.push_back({1'b0, 8'hEE});
    step(); check("ss_second_vo", valid_out, 1'b1); valid_in = 2'b00;
    step(); check("ss_third_vo", valid_out, 1'b1); check("ss_third_out", out, 8'hEE);
    step(); check("ss_vo_drop", valid_out, 1'b0);

    // Reset asserted between edges clears outputs without an edge
    step();
    #2 reset = 1'b1;
    #1 check("async_rst_out", out, '0);
       check("async_rst_vo", valid_out, 1'b0);
    step();
    reset = 1'b0;

    // Fair merge
    step(); valid_in = 2'b11; in0 = 8'hAA; in1 = 8'hCC;
            exp_q.push_back({1'b0, 8'hAA}); exp_q.push_back({1'b1, 8'hCC});
    step(); in0 = 8'hBB; in1 = 8'h99;
            exp_q.push_back({1'b0, 8'hBB}); exp_q.push_back({1'b1, 8'h99});
    step(); valid_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("fm_vo", valid_out, 1'b1);
      check("fm_sel", select_out, fm_sel[i][0]);
      step();
    end
    check("fm_idle", valid_out, 1'b0);

    // Full and overflow on input 1 under stall
    step(); stall = 1'b1; valid_in = 2'b10; in1 = 8'h88; exp_q.push_back({1'b1, 8'h88});
    step(); in1 = 8'h77; exp_q.push_back({1'b1, 8'h77});
    step(); in1 = 8'h66; exp_q.push_back({1'b1, 8'h66});
    step(); check("full_after3", full, 2'b00);
            in1 = 8'h55; exp_q.push_back({1'b1, 8'h55});
    step(); check("full_after4", full, 2'b10);
            check("ovf_before_drop", overflow, 2'b00);
            in1 = 8'h44;
    step(); check("ovf_pulse", overflow, 2'b10); valid_in = 2'b00;
    step(); check("ovf_clear", overflow, 2'b00); check("full_held", full, 2'b10);
            stall = 1'b0;
    step(); check("full_fall", full, 2'b00); check("ovf_first_out", out, 8'h88);
    drain("ovf_drain");

    // Reset mid-operation with words queued on both inputs
    step(); stall = 1'b1; valid_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in0 = 8'($urandom_range(0, 255));
      in1 = 8'($urandom_range(0, 255));
      step();
    end
    valid_in = 2'b00;
    #2 reset = 1'b1;
    #1 check_zero("mid_rst");
    step();
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_vo", valid_out, 1'b0);
    end

    // Wrap-around with stall toggling every 2 cycles
    pushed = 0;
    for (int c = 0; pushed < 10; c++) begin
      step();
      check("wrap_ovf", overflow, 2'b00);
      stall = c[1];
      if ((c % 4 == 1) || (c % 4 == 2)) begin
        valid_in = 2'b01;
        in0      = 8'(pushed + 1);
        exp_q.push_back({1'b0, 8'(pushed + 1)});
        pushed++;
      end else begin
        valid_in = 2'b00;
      end
    end
    step(); valid_in = 2'b00; stall = 1'b0;
    drain("wrap_drain");

    // Both inputs backlogged: strict alternation starting from input 0
    pulse_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      in0 = d0; in1 = d1; valid_in = 2'b11;
      exp_q.push_back({1'b0, d0});
      exp_q.push_back({1'b1, d1});
      step();
    end
    valid_in = 2'b00;
    check("bl_full", full, 2'b11);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("bl_vo", valid_out, 1'b1);
    end
    drain("bl_drain");

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
